// File: rtl/game_pkg.sv
// Shared encodings and widths for the game-flow controller.
// Optional pause support is enabled in game_sequencer with `define PAUSE_EN.
package game_pkg;

   localparam int STATE_W = 3;
   localparam int LIVES_W = 2;
   localparam int LEVEL_W = 4;

   typedef enum logic [STATE_W-1:0] {
      ST_ATTRACT    = 3'd0,
      ST_NEW_GAME   = 3'd1,
      ST_PLAYING    = 3'd2,
      ST_DEATH      = 3'd3,
      ST_WAVE_CLEAR = 3'd4,
      ST_GAME_OVER  = 3'd5,
      ST_PAUSED     = 3'd6
   } game_state_t;

   // Wave level advances by one and sticks at the ceiling.
   function automatic logic [LEVEL_W-1:0] level_inc(input logic [LEVEL_W-1:0] lvl,
                                                    input int max_level);
      if (int'(lvl) >= max_level) return LEVEL_W'(max_level);
      return lvl + LEVEL_W'(1);
   endfunction

endpackage

// File: rtl/game_sequencer_tick_divider.sv
// Free-running frame-rate divider: tick is high on the cycle the counter wraps.
module tick_divider #(
   parameter int TICK_DIV = 360000
) (
   input  logic clk_36MHz,
   input  logic reset,
   output logic tick
);

   localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [CNT_W-1:0] cnt;

   always_ff @(posedge clk_36MHz or posedge reset) begin
      if (reset)
         cnt <= '0;
      else if (cnt == CNT_W'(TICK_DIV - 1))
         cnt <= '0;
      else
         cnt <= cnt + CNT_W'(1);
   end

   assign tick = (cnt == CNT_W'(TICK_DIV - 1));

endmodule

// File: rtl/game_sequencer.sv
// Game-flow FSM: sequences attract/play/death/wave states, lives and level.
// Define PAUSE_EN to add the PAUSED state toggled by start during play.
module game_sequencer
   import game_pkg::*;
#(
   parameter int TICK_DIV   = 360000,
   parameter int HOLD_TICKS = 100,
   parameter int LIVES      = 3,
   parameter int MAX_LEVEL  = 15
) (
   input  logic               clk_36MHz,
   input  logic               reset,
   input  logic               start_debounced,
   input  logic               ship_destroyed,
   input  logic               wave_cleared,
   input  logic               invaders_landed,
   output logic               enable,
   output logic               clear,
   output logic               clear_score,
   output logic [STATE_W-1:0] game_state,
   output logic [LIVES_W-1:0] lives,
   output logic [LEVEL_W-1:0] level,
   output logic               game_over
);

   localparam int HOLD_W = $clog2(HOLD_TICKS + 1);

   game_state_t        state, state_nxt;
   logic               tick;
   logic [HOLD_W-1:0]  hold_cnt, hold_nxt;
   logic               hold_done;
   logic [LIVES_W-1:0] lives_nxt;
   logic [LEVEL_W-1:0] level_nxt;
   logic               enable_nxt, clear_nxt, clear_score_nxt, game_over_nxt;

   tick_divider #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk_36MHz (clk_36MHz),
      .reset     (reset),
      .tick      (tick)
   );

   assign hold_done  = (hold_cnt == HOLD_W'(HOLD_TICKS));
   assign game_state = state;

   always_ff @(posedge clk_36MHz or posedge reset) begin
      if (reset) begin
         state       <= ST_ATTRACT;
         hold_cnt    <= '0;
         lives       <= '0;
         level       <= '0;
         enable      <= 1'b0;
         clear       <= 1'b0;
         clear_score <= 1'b0;
         game_over   <= 1'b0;
      end else begin
         state       <= state_nxt;
         hold_cnt    <= hold_nxt;
         lives       <= lives_nxt;
         level       <= level_nxt;
         enable      <= enable_nxt;
         clear       <= clear_nxt;
         clear_score <= clear_score_nxt;
         game_over   <= game_over_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_ATTRACT:   if (start_debounced) state_nxt = ST_NEW_GAME;
         ST_NEW_GAME:  state_nxt = ST_PLAYING;
         ST_PLAYING: begin
            // Only the highest-priority event in a cycle is acted on.
            if (invaders_landed)
               state_nxt = ST_GAME_OVER;
            else if (ship_destroyed)
               state_nxt = (lives == LIVES_W'(1)) ? ST_GAME_OVER : ST_DEATH;
            else if (wave_cleared)
               state_nxt = ST_WAVE_CLEAR;
`ifdef PAUSE_EN
            else if (start_debounced)
               state_nxt = ST_PAUSED;
`endif
         end
         ST_DEATH, ST_WAVE_CLEAR: if (hold_done) state_nxt = ST_PLAYING;
         ST_GAME_OVER: if (start_debounced) state_nxt = ST_NEW_GAME;
`ifdef PAUSE_EN
         ST_PAUSED:    if (start_debounced) state_nxt = ST_PLAYING;
`endif
         default:      state_nxt = ST_ATTRACT;
      endcase
   end

   always_comb begin
      hold_nxt        = hold_cnt;
      lives_nxt       = lives;
      level_nxt       = level;
      clear_nxt       = 1'b0;
      clear_score_nxt = 1'b0;
      // enable requires PLAYING on both sides of the edge, so it never meets a clear.
      enable_nxt      = tick && (state == ST_PLAYING) && (state_nxt == ST_PLAYING);
      game_over_nxt   = (state_nxt == ST_GAME_OVER);
      case (state)
         ST_PLAYING: begin
            hold_nxt = '0;
            if (invaders_landed)
               lives_nxt = '0;
            else if (ship_destroyed)
               lives_nxt = lives - LIVES_W'(1);
         end
         ST_DEATH, ST_WAVE_CLEAR: begin
            if (hold_done) begin
               clear_nxt = 1'b1;
               if (state == ST_WAVE_CLEAR) level_nxt = level_inc(level, MAX_LEVEL);
            end else if (tick) begin
               hold_nxt = hold_cnt + HOLD_W'(1);
            end
         end
         default: ;
      endcase
      if (state_nxt == ST_NEW_GAME) begin
         clear_nxt       = 1'b1;
         clear_score_nxt = 1'b1;
         lives_nxt       = LIVES_W'(LIVES);
         level_nxt       = '0;
      end
   end

endmodule

// File: tb/tb_game_sequencer.sv
// Bench for game_sequencer: directed vector table, hand sequences and a random run.
module tb_game_sequencer;

   localparam int TICK_DIV   = 4;
   localparam int HOLD_TICKS = 2;
   localparam int LIVES      = 3;
   localparam int MAX_LEVEL  = 15;
`ifdef PAUSE_EN
   localparam bit PAUSE = 1'b1;
`else
   localparam bit PAUSE = 1'b0;
`endif

   localparam int S_ATTRACT = 0, S_NEW = 1, S_PLAY = 2, S_DEATH = 3,
                  S_WAVE = 4, S_OVER = 5, S_PAUSE = 6;

   logic       clk_36MHz = 1'b0;
   logic       reset = 1'b1;
   logic       start_debounced = 1'b0, ship_destroyed = 1'b0;
   logic       wave_cleared = 1'b0, invaders_landed = 1'b0;
   logic       enable, clear, clear_score, game_over;
   logic [2:0] game_state;
   logic [1:0] lives;
   logic [3:0] level;

   int checks = 0;
   int errors = 0;
   int clear_seen = 0;

   // behavioural model state
   int m_state, m_lives, m_level, m_hold, m_cnt;
   bit e_en, e_clr, e_clrs, e_go;

   typedef struct {
      bit st, sh, wc, il;
      int gs, lv, lvl;
      bit en, clr, clrs, go;
   } vec_t;

   vec_t vecs[16];

   game_sequencer #(
      .TICK_DIV(TICK_DIV), .HOLD_TICKS(HOLD_TICKS), .LIVES(LIVES), .MAX_LEVEL(MAX_LEVEL)
   ) dut (
      .clk_36MHz       (clk_36MHz),
      .reset           (reset),
      .start_debounced (start_debounced),
      .ship_destroyed  (ship_destroyed),
      .wave_cleared    (wave_cleared),
      .invaders_landed (invaders_landed),
      .enable          (enable),
      .clear           (clear),
      .clear_score     (clear_score),
      .game_state      (game_state),
      .lives           (lives),
      .level           (level),
      .game_over       (game_over)
   );

   always #5 clk_36MHz = ~clk_36MHz;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_state = S_ATTRACT; m_lives = 0; m_level = 0; m_hold = 0; m_cnt = 0;
      e_en = 0; e_clr = 0; e_clrs = 0; e_go = 0;
   endtask

   task automatic model_step(input bit st, input bit sh, input bit wc, input bit il);
      int ns;
      bit tick;
      tick = (m_cnt == TICK_DIV - 1);
      ns = m_state;
      e_clr = 0; e_clrs = 0;
      case (m_state)
         S_ATTRACT: if (st) ns = S_NEW;
         S_NEW:     ns = S_PLAY;
         S_PLAY: begin
            m_hold = 0;
            if (il) begin ns = S_OVER; m_lives = 0; end
            else if (sh) begin m_lives = m_lives - 1; ns = (m_lives == 0) ? S_OVER : S_DEATH; end
            else if (wc) ns = S_WAVE;
            else if (PAUSE && st) ns = S_PAUSE;
         end
         S_DEATH, S_WAVE: begin
            if (m_hold == HOLD_TICKS) begin
               ns = S_PLAY; e_clr = 1;
               if (m_state == S_WAVE && m_level < MAX_LEVEL) m_level++;
            end else if (tick) m_hold++;
         end
         S_OVER:  if (st) ns = S_NEW;
         S_PAUSE: if (st) ns = S_PLAY;
         default: ns = S_ATTRACT;
      endcase
      e_en = tick && (m_state == S_PLAY) && (ns == S_PLAY);
      if (ns == S_NEW) begin
         e_clr = 1; e_clrs = 1; m_lives = LIVES; m_level = 0;
      end
      m_state = ns;
      e_go = (ns == S_OVER);
      m_cnt = (m_cnt + 1) % TICK_DIV;
   endtask

   // Called between clock edges: drive, advance one edge, compare against the model.
   task automatic step(input bit st, input bit sh, input bit wc, input bit il);
      start_debounced = st; ship_destroyed = sh; wave_cleared = wc; invaders_landed = il;
      model_step(st, sh, wc, il);
      @(posedge clk_36MHz);
      #1;
      chk("state", int'(game_state), m_state);
      chk("lives", int'(lives), m_lives);
      chk("level", int'(level), m_level);
      chk("enable", int'(enable), int'(e_en));
      chk("clear", int'(clear), int'(e_clr));
      chk("clear_score", int'(clear_score), int'(e_clrs));
      chk("game_over", int'(game_over), int'(e_go));
      if (clear) clear_seen++;
   endtask

   task automatic do_reset();
      @(negedge clk_36MHz);
      reset = 1'b1;
      start_debounced = 0; ship_destroyed = 0; wave_cleared = 0; invaders_landed = 0;
      #1;
      chk("rst_state", int'(game_state), 0);
      chk("rst_lives", int'(lives), 0);
      chk("rst_level", int'(level), 0);
      chk("rst_enable", int'(enable), 0);
      chk("rst_clear", int'(clear), 0);
      chk("rst_clear_score", int'(clear_score), 0);
      chk("rst_game_over", int'(game_over), 0);
      model_reset();
      @(negedge clk_36MHz);
      reset = 1'b0;
   endtask

   task automatic wait_playing(input int budget);
      int n;
      n = 0;
      while (game_state != 3'(S_PLAY) && n < budget) begin
         step(0, 0, 0, 0);
         n++;
      end
      chk("wait_playing", int'(game_state), S_PLAY);
   endtask

   initial begin
      //          st sh wc il  gs lv lvl en clr clrs go
      vecs[0]  = '{1, 0, 0, 0, 1, 3, 0, 0, 1, 1, 0};
      vecs[1]  = '{0, 0, 0, 0, 2, 3, 0, 0, 0, 0, 0};
      vecs[2]  = '{0, 0, 0, 0, 2, 3, 0, 0, 0, 0, 0};
      vecs[3]  = '{0, 0, 0, 0, 2, 3, 0, 1, 0, 0, 0};
      vecs[4]  = '{0, 0, 0, 0, 2, 3, 0, 0, 0, 0, 0};
      vecs[5]  = '{0, 1, 0, 0, 3, 2, 0, 0, 0, 0, 0};
      vecs[6]  = '{0, 0, 0, 0, 3, 2, 0, 0, 0, 0, 0};
      vecs[7]  = '{0, 0, 0, 0, 3, 2, 0, 0, 0, 0, 0};
      vecs[8]  = '{0, 0, 0, 0, 3, 2, 0, 0, 0, 0, 0};
      vecs[9]  = '{0, 0, 0, 0, 3, 2, 0, 0, 0, 0, 0};
      vecs[10] = '{0, 0, 0, 0, 3, 2, 0, 0, 0, 0, 0};
      vecs[11] = '{0, 0, 0, 0, 3, 2, 0, 0, 0, 0, 0};
      vecs[12] = '{0, 0, 0, 0, 2, 2, 0, 0, 1, 0, 0};
      vecs[13] = '{0, 0, 0, 0, 2, 2, 0, 0, 0, 0, 0};
      vecs[14] = '{0, 0, 0, 0, 2, 2, 0, 0, 0, 0, 0};
      vecs[15] = '{0, 0, 0, 0, 2, 2, 0, 1, 0, 0, 0};

      model_reset();
      do_reset();

      // new game, play, one death and recovery
      foreach (vecs[i]) begin
         step(vecs[i].st, vecs[i].sh, vecs[i].wc, vecs[i].il);
         chk($sformatf("vec%0d_state", i), int'(game_state), vecs[i].gs);
         chk($sformatf("vec%0d_lives", i), int'(lives), vecs[i].lv);
         chk($sformatf("vec%0d_level", i), int'(level), vecs[i].lvl);
         chk($sformatf("vec%0d_enable", i), int'(enable), int'(vecs[i].en));
         chk($sformatf("vec%0d_clear", i), int'(clear), int'(vecs[i].clr));
         chk($sformatf("vec%0d_clear_score", i), int'(clear_score), int'(vecs[i].clrs));
         chk($sformatf("vec%0d_game_over", i), int'(game_over), int'(vecs[i].go));
      end

      // lose remaining lives -> game over, then restart
      step(0, 1, 0, 0);
      wait_playing(40);
      step(0, 1, 0, 0);
      chk("last_life_state", int'(game_state), S_OVER);
      chk("last_life_lives", int'(lives), 0);
      chk("last_life_game_over", int'(game_over), 1);
      repeat (5) step(0, 1, 1, 0);
      chk("over_frozen_lives", int'(lives), 0);
      step(1, 0, 0, 0);
      chk("restart_state", int'(game_state), S_NEW);
      chk("restart_lives", int'(lives), LIVES);
      chk("restart_clear_score", int'(clear_score), 1);
      step(0, 0, 0, 0);

      // level saturation
      clear_seen = 0;
      for (int w = 0; w < 16; w++) begin
         step(0, 0, 1, 0);
         wait_playing(40);
      end
      chk("level_sat", int'(level), MAX_LEVEL);
      chk("wave_clear_pulses", clear_seen, 16);
      chk("wave_lives_kept", int'(lives), LIVES);

      // simultaneous events: landing wins
      step(0, 1, 1, 1);
      chk("simul_state", int'(game_state), S_OVER);
      chk("simul_lives", int'(lives), 0);

      // reset while in DEATH
      step(1, 0, 0, 0);
      step(0, 0, 0, 0);
      step(0, 1, 0, 0);
      chk("pre_reset_death", int'(game_state), S_DEATH);
      do_reset();

      // start during play
      step(1, 0, 0, 0);
      wait_playing(10);
`ifdef PAUSE_EN
      step(1, 0, 0, 0);
      chk("pause_enter", int'(game_state), S_PAUSE);
      repeat (6) step(0, 1, 1, 0);
      chk("pause_hold_state", int'(game_state), S_PAUSE);
      chk("pause_lives", int'(lives), LIVES);
      step(1, 0, 0, 0);
      chk("pause_exit", int'(game_state), S_PLAY);
`else
      step(1, 0, 0, 0);
      chk("start_in_play", int'(game_state), S_PLAY);
      step(1, 0, 0, 0);
      chk("start_in_play2", int'(game_state), S_PLAY);
`endif

      // random traffic against the model
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         step($urandom_range(0, 11) == 0, $urandom_range(0, 24) == 0,
              $urandom_range(0, 19) == 0, $urandom_range(0, 79) == 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout actual=running expected=finished");
      $fatal(1, "bench timeout");
   end

endmodule
